// File: rtl/i3c_ram_1p_pipe.sv
// Single-port SRAM model for I3C descriptor/data queues.
// - req/gnt handshake with a read-valid strobe and an out-of-range error flag.
// - Configurable read-data pipeline depth.
// - Optional zero-fill sweep after every reset, during which requests stall.

module i3c_ram_1p_pipe #(
    parameter int Width           = 32,
    parameter int Depth           = 128,
    parameter int DataBitsPerMask = 8,
    parameter int OutRegs         = 0,
    parameter int ZeroInit        = 1,
    localparam int Aw             = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             write_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             rerr_o,
    output logic             init_done_o
);

    localparam int NumGroups = Width / DataBitsPerMask;
    localparam int Stages    = OutRegs + 1;

    // Depth widened by one bit so that a power-of-two Depth still compares correctly.
    localparam logic [Aw:0]   DepthW   = (Aw + 1)'(Depth);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                 state_r;
    logic [Aw-1:0]          init_cnt_r;
    logic                   init_done_r;

    logic [Width-1:0]       mem_r [Depth];

    logic                   gnt_s;
    logic                   rd_s;
    logic                   in_range_s;
    logic                   sweep_s;
    logic                   init_last_s;
    logic [NumGroups-1:0]   mem_we_s;
    logic [Aw-1:0]          mem_addr_s;
    logic [Width-1:0]       mem_wdata_s;

    logic [Width-1:0]       data_r  [Stages];
    logic                   valid_r [Stages];
    logic                   err_r   [Stages];

    // Requests are only accepted once the array is initialised; nothing is granted under reset.
    assign gnt_s       = req_i & init_done_r & ~rst_i;
    assign rd_s        = gnt_s & ~write_i;
    assign in_range_s  = ({1'b0, addr_i} < DepthW);
    assign sweep_s     = (state_r == ST_INIT) & ~rst_i;
    assign init_last_s = (init_cnt_r == LastAddr);

    // Init/ready state machine: sweeps one address per cycle, then flags init_done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= (ZeroInit != 0) ? ST_INIT : ST_READY;
            init_cnt_r  <= '0;
            init_done_r <= (ZeroInit != 0) ? 1'b0 : 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_last_s) begin
                        state_r     <= ST_READY;
                        init_done_r <= 1'b1;
                        init_cnt_r  <= '0;
                    end else begin
                        init_cnt_r  <= init_cnt_r + Aw'(1);
                    end
                end
                ST_READY: begin
                    state_r     <= ST_READY;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= (ZeroInit != 0) ? ST_INIT : ST_READY;
                    init_cnt_r  <= '0;
                    init_done_r <= (ZeroInit != 0) ? 1'b0 : 1'b1;
                end
            endcase
        end
    end

    // Array write port: the zero sweep has priority; out-of-range writes are dropped.
    always_comb begin
        mem_we_s    = '0;
        mem_addr_s  = addr_i;
        mem_wdata_s = wdata_i;
        if (sweep_s) begin
            mem_we_s    = '1;
            mem_addr_s  = init_cnt_r;
            mem_wdata_s = '0;
        end else if (gnt_s && write_i && in_range_s) begin
            for (int g = 0; g < NumGroups; g++) begin
                mem_we_s[g] = &wmask_i[g*DataBitsPerMask +: DataBitsPerMask];
            end
        end else begin
            mem_we_s = '0;
        end
    end

    // Storage array, written one mask group at a time; deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int g = 0; g < NumGroups; g++) begin
            if (mem_we_s[g]) begin
                mem_r[mem_addr_s][g*DataBitsPerMask +: DataBitsPerMask] <=
                    mem_wdata_s[g*DataBitsPerMask +: DataBitsPerMask];
            end
        end
    end

    // Read pipeline: stage 0 captures the array, later stages move only when carrying valid data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < Stages; k++) begin
                data_r[k]  <= '0;
                valid_r[k] <= 1'b0;
                err_r[k]   <= 1'b0;
            end
        end else begin
            valid_r[0] <= rd_s;
            err_r[0]   <= rd_s & ~in_range_s;
            if (rd_s) begin
                data_r[0] <= in_range_s ? mem_r[addr_i] : '0;
            end
            for (int k = 1; k < Stages; k++) begin
                valid_r[k] <= valid_r[k-1];
                err_r[k]   <= valid_r[k-1] & err_r[k-1];
                if (valid_r[k-1]) begin
                    data_r[k] <= data_r[k-1];
                end
            end
        end
    end

    assign gnt_o       = gnt_s;
    assign rdata_o     = data_r[Stages-1];
    assign rvalid_o    = valid_r[Stages-1];
    assign rerr_o      = err_r[Stages-1];
    assign init_done_o = init_done_r;

    i3c_ram_1p_pipe_chk #(
        .Width           (Width),
        .Depth           (Depth),
        .DataBitsPerMask (DataBitsPerMask),
        .OutRegs         (OutRegs),
        .Aw              (Aw)
    ) u_chk (
        .clk   (clk_i),
        .rst   (rst_i),
        .req   (req_i),
        .gnt   (gnt_s),
        .write (write_i),
        .addr  (addr_i),
        .wmask (wmask_i)
    );

endmodule

// Protocol and configuration checks for i3c_ram_1p_pipe.
module i3c_ram_1p_pipe_chk #(
    parameter int Width           = 32,
    parameter int Depth           = 128,
    parameter int DataBitsPerMask = 8,
    parameter int OutRegs         = 0,
    parameter int Aw              = 7
) (
    input logic             clk,
    input logic             rst,
    input logic             req,
    input logic             gnt,
    input logic             write,
    input logic [Aw-1:0]    addr,
    input logic [Width-1:0] wmask
);

    localparam int NumGroups = Width / DataBitsPerMask;

    if (OutRegs < 0 || OutRegs > 2) begin : g_bad_outregs
        $error("i3c_ram_1p_pipe: OutRegs must be in 0..2");
    end

    if ((Width % DataBitsPerMask) != 0) begin : g_bad_mask_groups
        $error("i3c_ram_1p_pipe: Width must be a multiple of DataBitsPerMask");
    end

    if (Depth < 2) begin : g_bad_depth
        $error("i3c_ram_1p_pipe: Depth must be at least 2");
    end

    // Every mask group must be all ones or all zeros.
    function automatic logic mask_uniform(input logic [Width-1:0] m);
        logic ok;
        ok = 1'b1;
        for (int g = 0; g < NumGroups; g++) begin
            if ((|m[g*DataBitsPerMask +: DataBitsPerMask]) &&
                !(&m[g*DataBitsPerMask +: DataBitsPerMask])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    a_mask_uniform: assert property (@(posedge clk) disable iff (rst)
        (gnt && write) |-> mask_uniform(wmask));

    a_hold_while_stalled: assert property (@(posedge clk) disable iff (rst)
        (req && !gnt) |=> ($stable(addr) && $stable(write)));

endmodule

// File: tb/tb_i3c_ram_1p_pipe.sv
// Bench for i3c_ram_1p_pipe: three instances cover OutRegs 2/0/1 and a non-power-of-two depth.
// Expected read data comes from a plain array model updated by the bench's own write rules.

module tb_i3c_ram_1p_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req       [3];
    logic        write     [3];
    logic [6:0]  addr      [3];
    logic [31:0] wdata     [3];
    logic [31:0] wmask     [3];
    logic        gnt       [3];
    logic [31:0] rdata     [3];
    logic        rvalid    [3];
    logic        rerr      [3];
    logic        init_done [3];

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: Depth 128, OutRegs 2; dut1: Depth 100, OutRegs 0; dut2: Depth 128, OutRegs 1
    int depth_of [3] = '{128, 100, 128};
    int lat_of   [3] = '{3, 1, 2};

    logic [31:0] mem_m [3][128];

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rd_t;

    always #5 clk = ~clk;

    i3c_ram_1p_pipe #(.Depth(128), .OutRegs(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .write_i(write[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .wmask_i(wmask[0]), .rdata_o(rdata[0]),
        .rvalid_o(rvalid[0]), .rerr_o(rerr[0]), .init_done_o(init_done[0]));

    i3c_ram_1p_pipe #(.Depth(100), .OutRegs(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .write_i(write[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .wmask_i(wmask[1]), .rdata_o(rdata[1]),
        .rvalid_o(rvalid[1]), .rerr_o(rerr[1]), .init_done_o(init_done[1]));

    i3c_ram_1p_pipe #(.Depth(128), .OutRegs(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .write_i(write[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .wmask_i(wmask[2]), .rdata_o(rdata[2]),
        .rvalid_o(rvalid[2]), .rerr_o(rerr[2]), .init_done_o(init_done[2]));

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 128; a++)
                mem_m[d][a] = 32'h0;
    endtask

    task automatic model_write(input int d, input logic [6:0] a, input logic [31:0] wd, input logic [31:0] m);
        if (int'(a) < depth_of[d]) begin
            for (int g = 0; g < 4; g++)
                if (&m[g*8 +: 8]) mem_m[d][a][g*8 +: 8] = wd[g*8 +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [6:0] a);
        return (int'(a) < depth_of[d]) ? mem_m[d][a] : 32'h0;
    endfunction

    // Present one request (caller is at a falling edge); it must be granted straight away.
    task automatic drive(input int d, input logic wr, input logic [6:0] a, input logic [31:0] wd, input logic [31:0] m);
        req[d] = 1'b1; write[d] = wr; addr[d] = a; wdata[d] = wd; wmask[d] = m;
        #1;
        n_checks++;
        if (gnt[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL gnt dut%0d addr %0d: got %b want 1", d, a, gnt[d]);
        end
        if (wr) model_write(d, a, wd, m);
    endtask

    task automatic write_op(input int d, input logic [6:0] a, input logic [31:0] wd, input logic [31:0] m);
        @(negedge clk);
        drive(d, 1'b1, a, wd, m);
    endtask

    task automatic end_burst(input int d);
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    // Single read with exact latency, data and error checks.
    task automatic read_check(input int d, input logic [6:0] a);
        logic [31:0] exp_d;
        logic        exp_e;
        @(negedge clk);
        exp_d = model_read(d, a);
        exp_e = (int'(a) >= depth_of[d]);
        drive(d, 1'b0, a, 32'h0, 32'h0);
        for (int k = 1; k <= lat_of[d] + 1; k++) begin
            @(negedge clk);
            if (k == 1) req[d] = 1'b0;
            n_checks++;
            if (rvalid[d] !== (k == lat_of[d])) begin
                n_fail++;
                $display("FAIL rvalid_latency dut%0d addr %0d cyc %0d: got %b want %b", d, a, k, rvalid[d], (k == lat_of[d]));
            end
            if (k == lat_of[d]) begin
                n_checks++;
                if (rdata[d] !== exp_d || rerr[d] !== exp_e) begin
                    n_fail++;
                    $display("FAIL read_data dut%0d addr %0d: got %h/%b want %h/%b", d, a, rdata[d], rerr[d], exp_d, exp_e);
                end
            end
        end
    endtask

    // Release reset and check the sweep length; dut0/dut2 hold a read of address 5 meanwhile.
    task automatic release_and_sweep();
        req[0] = 1'b1; write[0] = 1'b0; addr[0] = 7'd5;
        req[2] = 1'b1; write[2] = 1'b0; addr[2] = 7'd5;
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        for (int c = 0; c <= 128; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            for (int d = 0; d < 3; d++) begin
                n_checks += 2;
                if (init_done[d] !== (c >= depth_of[d])) begin
                    n_fail++;
                    $display("FAIL init_done dut%0d cyc %0d: got %b want %b", d, c, init_done[d], (c >= depth_of[d]));
                end
                if (rvalid[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rvalid_in_init dut%0d cyc %0d: got %b want 0", d, c, rvalid[d]);
                end
            end
            for (int d = 0; d < 3; d += 2) begin
                n_checks++;
                if (gnt[d] !== (c >= 128)) begin
                    n_fail++;
                    $display("FAIL gnt_in_init dut%0d cyc %0d: got %b want %b", d, c, gnt[d], (c >= 128));
                end
            end
        end
        req[0] = 1'b0;
        req[2] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req[0] = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (gnt[d] !== 1'b0 || rdata[d] !== 32'h0 || rvalid[d] !== 1'b0 || rerr[d] !== 1'b0 || init_done[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got gnt %b rdata %h rvalid %b rerr %b init %b want all 0",
                         d, gnt[d], rdata[d], rvalid[d], rerr[d], init_done[d]);
            end
        end
        release_and_sweep();
        read_check(0, 7'd5);
        read_check(2, 7'd5);
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req[0] = 1'b1;
        for (int c = 0; c < 40; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (init_done[0] !== 1'b0 || gnt[0] !== 1'b0 || rvalid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_init_reset: got init %b gnt %b rvalid %b want 0 0 0", init_done[0], gnt[0], rvalid[0]);
        end
        release_and_sweep();
    endtask

    task automatic test_write_read();
        write_op(0, 7'd3, 32'hDEADBEEF, 32'hFFFFFFFF);
        read_check(0, 7'd3);
    endtask

    task automatic test_masked_write();
        write_op(0, 7'd7, 32'h11223344, 32'hFFFFFFFF);
        write_op(0, 7'd7, 32'hAABBCCDD, 32'h00FF00FF);
        read_check(0, 7'd7);
    endtask

    task automatic test_out_of_range();
        write_op(1, 7'd14, 32'hCAFEF00D, 32'hFFFFFFFF);
        write_op(1, 7'd10, 32'h12345678, 32'hFFFFFFFF);
        write_op(1, 7'd110, 32'hFFFFFFFF, 32'hFFFFFFFF);
        end_burst(1);
        read_check(1, 7'd120);
        read_check(1, 7'd110);
        read_check(1, 7'd14);
        read_check(1, 7'd10);
        read_check(1, 7'd99);
    endtask

    task automatic test_back_to_back();
        int j;
        for (int i = 0; i < 16; i++) write_op(2, 7'(i), 32'(i), 32'hFFFFFFFF);
        for (int k = 0; k <= 16 + lat_of[2]; k++) begin
            @(negedge clk);
            j = k - lat_of[2];
            n_checks++;
            if (rvalid[2] !== (j >= 0 && j < 16)) begin
                n_fail++;
                $display("FAIL stream_valid cyc %0d: got %b want %b", k, rvalid[2], (j >= 0 && j < 16));
            end
            if (j >= 0 && j < 16) begin
                n_checks++;
                if (rdata[2] !== mem_m[2][j] || rerr[2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_data idx %0d: got %h/%b want %h/0", j, rdata[2], rerr[2], mem_m[2][j]);
                end
            end else if (j >= 16) begin
                n_checks++;
                if (rdata[2] !== mem_m[2][15]) begin
                    n_fail++;
                    $display("FAIL stream_hold: got %h want %h", rdata[2], mem_m[2][15]);
                end
            end
            if (k < 16) drive(2, 1'b0, 7'(k), 32'h0, 32'h0);
            else req[2] = 1'b0;
        end
    endtask

    // Random mix of idles, masked writes and reads against the array model and a due-cycle queue.
    task automatic test_random(input int d);
        rd_t         q[$];
        rd_t         e;
        logic [31:0] last;
        logic        have_last;
        logic [31:0] m;
        logic [6:0]  a;
        int          op;
        have_last = 1'b0;
        last = 32'h0;
        for (int k = 0; k <= 200 + lat_of[d]; k++) begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == k) begin
                e = q.pop_front();
                n_checks++;
                if (rvalid[d] !== 1'b1 || rdata[d] !== e.data || rerr[d] !== e.err) begin
                    n_fail++;
                    $display("FAIL rand_read dut%0d cyc %0d: got %b/%h/%b want 1/%h/%b", d, k, rvalid[d], rdata[d], rerr[d], e.data, e.err);
                end
                last = e.data;
                have_last = 1'b1;
            end else begin
                n_checks++;
                if (rvalid[d] !== 1'b0 || rerr[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle dut%0d cyc %0d: got rvalid %b rerr %b want 0 0", d, k, rvalid[d], rerr[d]);
                end
                if (have_last) begin
                    n_checks++;
                    if (rdata[d] !== last) begin
                        n_fail++;
                        $display("FAIL rand_hold dut%0d cyc %0d: got %h want %h", d, k, rdata[d], last);
                    end
                end
            end
            if (k < 200) begin
                op = $urandom_range(0, 3);
                a = 7'($urandom_range(0, 127));
                if (op == 0) begin
                    req[d] = 1'b0;
                end else if (op == 1) begin
                    for (int g = 0; g < 4; g++) m[g*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                    drive(d, 1'b1, a, $urandom, m);
                end else begin
                    e.due = k + lat_of[d];
                    e.data = model_read(d, a);
                    e.err = (int'(a) >= depth_of[d]);
                    q.push_back(e);
                    drive(d, 1'b0, a, 32'h0, 32'h0);
                end
            end else begin
                req[d] = 1'b0;
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_missing dut%0d: got %0d pending reads want 0", d, q.size());
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; write[d] = 1'b0; addr[d] = 7'd0; wdata[d] = 32'h0; wmask[d] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_masked_write();
        test_out_of_range();
        test_back_to_back();
        test_random(0);
        test_random(1);
        test_random(2);
        test_reset_mid_init();
        read_check(0, 7'd3);
        read_check(1, 7'd14);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
